// File: rtl/sdram_rw_arbiter.sv
// Arbitrates SDRAM burst slots between the camera write FIFO and the display read FIFO.
// Optional ping-pong frame banks are enabled by defining DOUBLE_BUFFER_EN.
module sdram_rw_arbiter #(
    parameter int BURST_LEN     = 64,
    parameter int FRAME_WORDS   = 384000,
    parameter int RD_FIFO_DEPTH = 1024,
    parameter int RD_URGENT     = 256
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        init_done,
    input  logic [10:0] wr_fifo_level,
    input  logic [10:0] rd_fifo_level,
    input  logic        frame_start_wr,
    input  logic        frame_start_rd,
    output logic        cmd_req,
    output logic        cmd_wr,
    output logic [19:0] cmd_addr,
    output logic [7:0]  cmd_len,
    input  logic        cmd_ack,
    input  logic        cmd_done,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_BUSY, RD_REQ, RD_BUSY} state_e;

    localparam logic [10:0] WR_THRESH  = 11'(BURST_LEN);
    localparam logic [10:0] RD_THRESH  = 11'(RD_FIFO_DEPTH - BURST_LEN);
    localparam logic [10:0] URG_THRESH = 11'(RD_URGENT);
    localparam logic [19:0] ADDR_STEP  = 20'(BURST_LEN);
    localparam logic [19:0] ADDR_END   = 20'(FRAME_WORDS);
    localparam logic [7:0]  LEN        = 8'(BURST_LEN);

    state_e      state_q, state_d;
    logic [18:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic        wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
    logic        last_wr_q, last_wr_d;
    logic        wr_elig, rd_elig, rd_urgent;
    logic        grant_wr, grant_rd;
    logic        wr_bank, rd_bank;

    function automatic logic [18:0] next_addr(input logic [18:0] a);
        logic [19:0] sum;
        sum = {1'b0, a} + ADDR_STEP;
        return (sum >= ADDR_END) ? '0 : sum[18:0];
    endfunction

    always_comb begin
        wr_elig   = wr_fifo_level >= WR_THRESH;
        rd_elig   = rd_fifo_level <= RD_THRESH;
        rd_urgent = rd_fifo_level < URG_THRESH;
        grant_wr  = 1'b0;
        grant_rd  = 1'b0;
        // A starving display beats fairness; otherwise alternate when both sides want the bus
        if (state_q == IDLE && init_done) begin
            if (rd_urgent) begin
                grant_rd = 1'b1;
            end else if (wr_elig && rd_elig) begin
                grant_wr = ~last_wr_q;
                grant_rd = last_wr_q;
            end else if (wr_elig) begin
                grant_wr = 1'b1;
            end else if (rd_elig) begin
                grant_rd = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_wr) state_d = WR_REQ;
                     else if (grant_rd) state_d = RD_REQ;
            WR_REQ:  if (cmd_ack) state_d = WR_BUSY;
            WR_BUSY: if (cmd_done) state_d = IDLE;
            RD_REQ:  if (cmd_ack) state_d = RD_BUSY;
            RD_BUSY: if (cmd_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_req  = (state_q == WR_REQ) || (state_q == RD_REQ);
        cmd_wr   = (state_q == WR_REQ) || (state_q == WR_BUSY);
        busy     = state_q != IDLE;
        cmd_len  = cmd_req ? LEN : '0;
        cmd_addr = '0;
        if (state_q == WR_REQ)      cmd_addr = {wr_bank, wr_addr_q};
        else if (state_q == RD_REQ) cmd_addr = {rd_bank, rd_addr_q};
    end

    // Frame restarts are deferred to IDLE so an in-flight burst keeps its address
    always_comb begin
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        wr_pend_d = wr_pend_q | frame_start_wr;
        rd_pend_d = rd_pend_q | frame_start_rd;
        last_wr_d = last_wr_q;
        if (state_q == WR_BUSY && cmd_done) begin
            wr_addr_d = next_addr(wr_addr_q);
            last_wr_d = 1'b1;
        end
        if (state_q == RD_BUSY && cmd_done) begin
            rd_addr_d = next_addr(rd_addr_q);
            last_wr_d = 1'b0;
        end
        if (state_q == IDLE && wr_pend_q) begin
            wr_addr_d = '0;
            wr_pend_d = frame_start_wr;
        end
        if (state_q == IDLE && rd_pend_q) begin
            rd_addr_d = '0;
            rd_pend_d = frame_start_rd;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            wr_pend_q <= 1'b0;
            rd_pend_q <= 1'b0;
            last_wr_q <= 1'b0;
        end else begin
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            wr_pend_q <= wr_pend_d;
            rd_pend_q <= rd_pend_d;
            last_wr_q <= last_wr_d;
        end
    end

`ifdef DOUBLE_BUFFER_EN
    logic wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d, done_bank_q, done_bank_d;

    // The bank just closed by a camera frame restart becomes the one the display reads next
    always_comb begin
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        done_bank_d = done_bank_q;
        if (state_q == IDLE && wr_pend_q) begin
            done_bank_d = wr_bank_q;
            wr_bank_d   = ~wr_bank_q;
        end
        if (state_q == IDLE && rd_pend_q) rd_bank_d = done_bank_d;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            done_bank_q <= 1'b0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            done_bank_q <= done_bank_d;
        end
    end

    assign wr_bank = wr_bank_q;
    assign rd_bank = rd_bank_q;
`else
    assign wr_bank = 1'b0;
    assign rd_bank = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_rw_arbiter.sv
// Randomized self-checking bench for sdram_rw_arbiter against a transaction-level model.
module tb_sdram_rw_arbiter;

    localparam int BURST_LEN     = 64;
    localparam int FRAME_WORDS   = 384000;
    localparam int RD_FIFO_DEPTH = 1024;
    localparam int RD_URGENT     = 256;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        init_done;
    logic [10:0] wrLevel, rdLevel;
    logic        frame_start_wr, frame_start_rd;
    logic        cmd_req, cmd_wr, cmd_ack, cmd_done, busy;
    logic [19:0] cmd_addr;
    logic [7:0]  cmd_len;

    int testCount = 0;
    int failCount = 0;

    // Reference model state: per-side frame offset, pending restarts, fairness pointer, banks
    int   mWrAddr, mRdAddr;
    bit   mLastWr, mWrPend, mRdPend;
    bit   mWrBank, mRdBank, mDoneBank;
    logic [19:0] lastAddr;
    bit   lastWr;

    sdram_rw_arbiter #(
        .BURST_LEN(BURST_LEN), .FRAME_WORDS(FRAME_WORDS),
        .RD_FIFO_DEPTH(RD_FIFO_DEPTH), .RD_URGENT(RD_URGENT)
    ) dut (
        .CLK(CLK), .RSTn(RSTn), .init_done(init_done),
        .wr_fifo_level(wrLevel), .rd_fifo_level(rdLevel),
        .frame_start_wr(frame_start_wr), .frame_start_rd(frame_start_rd),
        .cmd_req(cmd_req), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .cmd_ack(cmd_ack), .cmd_done(cmd_done), .busy(busy)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic void resetModel();
        mWrAddr = 0; mRdAddr = 0;
        mLastWr = 0; mWrPend = 0; mRdPend = 0;
        mWrBank = 0; mRdBank = 0; mDoneBank = 0;
    endfunction

    function automatic void applyPendingModel();
        if (mWrPend) begin
            mWrAddr = 0;
`ifdef DOUBLE_BUFFER_EN
            mDoneBank = mWrBank;
            mWrBank   = ~mWrBank;
`endif
            mWrPend = 0;
        end
        if (mRdPend) begin
            mRdAddr = 0;
`ifdef DOUBLE_BUFFER_EN
            mRdBank = mDoneBank;
`endif
            mRdPend = 0;
        end
    endfunction

    // 0 = nothing granted, 1 = write, 2 = read
    function automatic int expectedGrant(input int wr, input int rd);
        bit we, re;
        we = wr >= BURST_LEN;
        re = rd <= RD_FIFO_DEPTH - BURST_LEN;
        if (rd < RD_URGENT) return 2;
        if (we && re) return mLastWr ? 2 : 1;
        if (we) return 1;
        if (re) return 2;
        return 0;
    endfunction

    function automatic int advance(input int a);
        return (a + BURST_LEN >= FRAME_WORDS) ? 0 : a + BURST_LEN;
    endfunction

    // Called at a negedge with the FSM idle and eligible levels already driven
    task automatic applyStimulus(input int ackDelay, input int doneDelay,
                                 input logic [1:0] fsBusy, input logic [1:0] fsDone);
        int g, lat;
        logic [19:0] expAddr;
        applyPendingModel();
        g = expectedGrant(int'(wrLevel), int'(rdLevel));
        expAddr = (g == 1) ? {mWrBank, 19'(mWrAddr)} : {mRdBank, 19'(mRdAddr)};
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (!cmd_req && lat < 20);
        checkOutput("reqLatency", lat, 1);
        if (!cmd_req) return;
        lastWr   = cmd_wr;
        lastAddr = cmd_addr;
        checkOutput("cmdWr", 32'(cmd_wr), 32'(g == 1));
        checkOutput("cmdAddr", 32'(cmd_addr), 32'(expAddr));
        checkOutput("cmdLen", 32'(cmd_len), BURST_LEN);
        for (int i = 0; i < ackDelay; i++) begin
            cmd_done = 1'($urandom_range(0, 1));
            @(negedge CLK);
            checkOutput("reqHold", 32'(cmd_req), 1);
            checkOutput("addrHold", 32'(cmd_addr), 32'(expAddr));
        end
        cmd_done = 1'b0;
        cmd_ack  = 1'b1;
        @(negedge CLK);
        cmd_ack = 1'b0;
        checkOutput("reqDrop", 32'(cmd_req), 0);
        checkOutput("busyHigh", 32'(busy), 1);
        frame_start_wr = fsBusy[0];
        frame_start_rd = fsBusy[1];
        for (int i = 0; i < doneDelay; i++) begin
            @(negedge CLK);
            frame_start_wr = 1'b0;
            frame_start_rd = 1'b0;
        end
        cmd_done       = 1'b1;
        frame_start_wr = frame_start_wr | fsDone[0];
        frame_start_rd = frame_start_rd | fsDone[1];
        @(negedge CLK);
        cmd_done       = 1'b0;
        frame_start_wr = 1'b0;
        frame_start_rd = 1'b0;
        checkOutput("busyLow", 32'(busy), 0);
        if (g == 1) begin
            mWrAddr = advance(mWrAddr);
            mLastWr = 1;
        end else begin
            mRdAddr = advance(mRdAddr);
            mLastWr = 0;
        end
        mWrPend = mWrPend | fsBusy[0] | fsDone[0];
        mRdPend = mRdPend | fsBusy[1] | fsDone[1];
        applyPendingModel();
    endtask

    // Neither side eligible: no command may appear, stray cmd_done must be ignored
    task automatic idleHold(input int cycles);
        int hits;
        logic [1:0] fs;
        hits = 0;
        fs = 2'($urandom_range(0, 3));
        wrLevel = 11'($urandom_range(0, BURST_LEN - 1));
        rdLevel = 11'($urandom_range(RD_FIFO_DEPTH - BURST_LEN + 1, RD_FIFO_DEPTH));
        frame_start_wr = fs[0];
        frame_start_rd = fs[1];
        for (int i = 0; i < cycles; i++) begin
            @(negedge CLK);
            frame_start_wr = 1'b0;
            frame_start_rd = 1'b0;
            if (cmd_req) hits++;
            cmd_done = (i < cycles - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        checkOutput("idleNoReq", hits, 0);
        mWrPend = mWrPend | fs[0];
        mRdPend = mRdPend | fs[1];
        applyPendingModel();
    endtask

    initial begin
        int hits, lat;
        bit seenEnd, wrapped;
        RSTn = 1'b0; init_done = 1'b0;
        wrLevel = '0; rdLevel = '0;
        frame_start_wr = 1'b0; frame_start_rd = 1'b0;
        cmd_ack = 1'b0; cmd_done = 1'b0;
        resetModel();
        #12;
        checkOutput("rstReq", 32'(cmd_req), 0);
        checkOutput("rstBusy", 32'(busy), 0);
        checkOutput("rstAddr", 32'(cmd_addr), 0);
        checkOutput("rstWr", 32'(cmd_wr), 0);
        @(negedge CLK);
        RSTn = 1'b1;

        // Controller not yet initialised: both sides would otherwise be eligible
        wrLevel = 11'd200; rdLevel = 11'd500;
        hits = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (cmd_req) hits++;
        end
        checkOutput("initHold", hits, 0);

        init_done = 1'b1;
        wrLevel = 11'd64; rdLevel = 11'd900;
        applyStimulus(1, 2, 2'b00, 2'b00);
        checkOutput("firstIsWrite", 32'(lastWr), 1);
        checkOutput("firstWrAddr", 32'(lastAddr), 0);
        applyStimulus(0, 1, 2'b00, 2'b00);
        checkOutput("altIsRead", 32'(lastWr), 0);
        applyStimulus(0, 0, 2'b00, 2'b00);
        checkOutput("secondWrAddr", 32'(lastAddr), 64);

        wrLevel = 11'd512; rdLevel = 11'd100;
        applyStimulus(0, 0, 2'b00, 2'b00);
        applyStimulus(0, 0, 2'b00, 2'b00);
        checkOutput("urgentRead", 32'(lastWr), 0);

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 3) == 0) idleHold(4 + $urandom_range(0, 3));
            wrLevel = 11'($urandom_range(0, RD_FIFO_DEPTH));
            rdLevel = 11'($urandom_range(0, RD_FIFO_DEPTH));
            if (expectedGrant(int'(wrLevel), int'(rdLevel)) == 0)
                wrLevel = 11'($urandom_range(BURST_LEN, RD_FIFO_DEPTH));
            applyStimulus($urandom_range(0, 2), $urandom_range(0, 2),
                          {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)},
                          {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)});
        end

        // Frame restart mid-write must not disturb the burst but zero the next one
        wrLevel = 11'd512; rdLevel = 11'd1000;
        applyStimulus(0, 2, 2'b01, 2'b00);
        applyStimulus(0, 0, 2'b00, 2'b00);
        checkOutput("fsWrAddr", 32'(lastAddr[18:0]), 0);

        seenEnd = 0; wrapped = 0;
        for (int n = 0; n < 6100 && !wrapped; n++) begin
            applyStimulus(0, 0, 2'b00, 2'b00);
            if (seenEnd) begin
                checkOutput("wrapAddr", 32'(lastAddr[18:0]), 0);
                wrapped = 1;
            end
            if (lastAddr[18:0] == 19'(FRAME_WORDS - BURST_LEN)) seenEnd = 1;
        end
        checkOutput("wrapSeen", 32'(wrapped), 1);

        // Reset in the middle of a read burst
        wrLevel = 11'd0; rdLevel = 11'd100;
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (!cmd_req && lat < 20);
        checkOutput("rdReqSeen", 32'(cmd_req), 1);
        cmd_ack = 1'b1;
        @(negedge CLK);
        cmd_ack = 1'b0;
        checkOutput("rdBusy", 32'(busy), 1);
        #2 RSTn = 1'b0;
        #1;
        checkOutput("midRstReq", 32'(cmd_req), 0);
        checkOutput("midRstBusy", 32'(busy), 0);
        checkOutput("midRstWr", 32'(cmd_wr), 0);
        checkOutput("midRstAddr", 32'(cmd_addr), 0);
        resetModel();
        @(negedge CLK);
        RSTn = 1'b1;
        wrLevel = 11'd512; rdLevel = 11'd1000;
        applyStimulus(0, 1, 2'b00, 2'b00);
        checkOutput("postRstWrAddr", 32'(lastAddr), 0);
        wrLevel = 11'd0; rdLevel = 11'd100;
        applyStimulus(1, 0, 2'b00, 2'b00);
        checkOutput("postRstRdAddr", 32'(lastAddr), 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
